// File: rtl/nanorv32_prefetch_q.sv
// nanorv32_prefetch_q: AHB-Lite instruction prefetch queue with credit-based issue,
// zero-cycle redirect, per-entry PC and bus-error halt.
module nanorv32_prefetch_q #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] FILL_INST = 32'h0000_006F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic [31:0] haddri,
  output logic        htransi,
  output logic [2:0]  hsizei,
  output logic        hwritei,
  input  logic        hreadyi,
  input  logic [31:0] hrdatai,
  input  logic        hrespi
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } entry_t;
  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, dp_pc_q, dp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dp_pending_q, dp_pending_d, discard_q, discard_d, halted_q, halted_d;
  logic          accept, complete, push, pop;
  logic [CW:0]   need;
  assign hsizei  = 3'b010;
  assign hwritei = 1'b0;
  always_comb begin
    // an in-flight beat holds a slot, so a full queue can never be overrun
    need         = {1'b0, count_q} + (CW+1)'(dp_pending_q) + (CW+1)'(1);
    htransi      = rst_n & fetch_en & ~halted_q & (need <= (CW+1)'(DEPTH));
    haddri       = flush ? flush_pc : fetch_pc_q;
    accept       = htransi & hreadyi;
    complete     = dp_pending_q & hreadyi;
    push         = complete & ~discard_q & ~flush;
    inst_valid   = count_q != '0;
    pop          = inst_valid & inst_ready & ~flush;
    inst_data    = inst_valid ? mem_q[rd_ptr_q].data : FILL_INST;
    inst_pc      = inst_valid ? mem_q[rd_ptr_q].pc : '0;
    inst_err     = inst_valid & mem_q[rd_ptr_q].err;
    fetch_pc_d   = haddri + (accept ? 32'd4 : 32'd0);
    dp_pc_d      = accept ? haddri : dp_pc_q;
    dp_pending_d = accept | (dp_pending_q & ~hreadyi);
    // a beat stalled across a flush belongs to the old stream and is dropped on arrival
    discard_d    = (flush | discard_q) & dp_pending_q & ~hreadyi;
    halted_d     = ~flush & (halted_q | (push & hrespi));
    wr_ptr_d     = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d     = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d      = flush ? '0 : count_q + CW'(push) - CW'(pop);
    mem_d        = mem_q;
    if (push) mem_d[wr_ptr_q] = {hrdatai, dp_pc_q, hrespi};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q        <= '0;
      fetch_pc_q   <= RESET_PC;
      dp_pc_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      dp_pending_q <= 1'b0;
      discard_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      fetch_pc_q   <= fetch_pc_d;
      dp_pc_q      <= dp_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      dp_pending_q <= dp_pending_d;
      discard_q    <= discard_d;
      halted_q     <= halted_d;
    end
  end
endmodule
